fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC, one-deep request credit and circular instruction queue.
// Optional same-cycle response bypass when FETCH_QUEUE_BYPASS_EN is defined.  Revision: 1.0
`default_nettype none

module fetch_queue #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] INITIAL_PC = '0
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    output logic [XLEN-1:0]            imem_addr_o,
    output logic                       imem_req_o,
    input  logic                       imem_ready_i,
    input  logic                       imem_rvalid_i,
    input  logic [XLEN-1:0]            imem_rdata_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       out_valid_o,
    output logic [XLEN-1:0]            out_instr_o,
    output logic [XLEN-1:0]            out_pc_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            inflight_q, inflight_d;
    logic            flush_q, flush_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic [AW:0]     wptr_q, wptr_d;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [AW:0]     occ;
    logic            empty;
    logic            full;
    logic            credit_ok;
    logic            accept;
    logic            resp_ok;
    logic            bypass;
    logic            bypass_take;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;

    assign occ       = wptr_q - rptr_q;
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // Credit counts the single outstanding request so a push can never find the queue full.
    assign credit_ok = ({1'b0, occ} + {{(AW+1){1'b0}}, inflight_q}) < (AW+2)'(DEPTH);

    assign imem_req_o  = reset_ni && !redirect_i && credit_ok;
    assign imem_addr_o = pc_q;
    assign occupancy_o = occ;
    assign accept      = imem_req_o && imem_ready_i;
    assign resp_ok     = imem_rvalid_i && inflight_q && !flush_q && !redirect_i;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && resp_ok;
`else
    assign bypass = 1'b0;
`endif

    assign bypass_take = bypass && out_ready_i;
    assign push        = resp_ok && !bypass_take && !full;
    assign pop         = !empty && out_ready_i && !redirect_i;

    always_comb begin
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        inflight_d = 1'b0;
        flush_d    = 1'b0;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        if (redirect_i) begin
            pc_d    = redirect_pc_i & ~XLEN'(3);
            rptr_d  = wptr_q;
            flush_d = 1'b1;
        end else begin
            wptr_d = wptr_q + {{AW{1'b0}}, push};
            rptr_d = rptr_q + {{AW{1'b0}}, pop};
            if (accept) begin
                pc_d       = pc_q + XLEN'(4);
                ipc_d      = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q       <= INITIAL_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
            flush_q    <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
            flush_q    <= flush_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clock_i) begin
        if (push) begin
            instr_mem[wptr_q[AW-1:0]] <= imem_rdata_i;
            pc_mem[wptr_q[AW-1:0]]    <= ipc_q;
        end
    end

    assign head_instr = instr_mem[rptr_q[AW-1:0]];
    assign head_pc    = pc_mem[rptr_q[AW-1:0]];

`ifdef FETCH_QUEUE_BYPASS_EN
    always_comb begin
        out_valid_o = !empty || bypass;
        out_instr_o = '0;
        out_pc_o    = '0;
        if (!empty) begin
            out_instr_o = head_instr;
            out_pc_o    = head_pc;
        end else if (bypass) begin
            out_instr_o = imem_rdata_i;
            out_pc_o    = ipc_q;
        end
    end
`else
    always_comb begin
        out_valid_o = !empty;
        out_instr_o = '0;
        out_pc_o    = '0;
        if (!empty) begin
            out_instr_o = head_instr;
            out_pc_o    = head_pc;
        end
    end
`endif

endmodule

`default_nettype wire
